// File: rtl/cci_channel_mux_if.sv
// Bundle of the client-side request/response signals and the host-facing CCI-P
// channel signals handled by cci_channel_mux.
interface cci_channel_mux_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 42,
    parameter int DATA_W      = 512,
    parameter int MDATA_W     = 16
);
    logic [NUM_CLIENTS-1:0]         cl_rd_valid;
    logic [NUM_CLIENTS-1:0]         cl_rd_ready;
    logic [NUM_CLIENTS*ADDR_W-1:0]  cl_rd_addr;
    logic [NUM_CLIENTS*MDATA_W-1:0] cl_rd_mdata;
    logic [NUM_CLIENTS-1:0]         cl_wr_valid;
    logic [NUM_CLIENTS-1:0]         cl_wr_ready;
    logic [NUM_CLIENTS*ADDR_W-1:0]  cl_wr_addr;
    logic [NUM_CLIENTS*DATA_W-1:0]  cl_wr_data;
    logic [NUM_CLIENTS*MDATA_W-1:0] cl_wr_mdata;

    logic                           fiu_c0_valid;
    logic [ADDR_W-1:0]              fiu_c0_addr;
    logic [MDATA_W-1:0]             fiu_c0_mdata;
    logic [2:0]                     fiu_c0_flags;
    logic                           fiu_c1_valid;
    logic [ADDR_W-1:0]              fiu_c1_addr;
    logic [DATA_W-1:0]              fiu_c1_data;
    logic [MDATA_W-1:0]             fiu_c1_mdata;
    logic [2:0]                     fiu_c1_flags;
    logic                           fiu_c0_almfull;
    logic                           fiu_c1_almfull;

    logic                           fiu_rd_rsp_valid;
    logic [MDATA_W-1:0]             fiu_rd_rsp_mdata;
    logic [DATA_W-1:0]              fiu_rd_rsp_data;
    logic                           fiu_wr_rsp_valid;
    logic [MDATA_W-1:0]             fiu_wr_rsp_mdata;

    logic [NUM_CLIENTS-1:0]         cl_rd_rsp_valid;
    logic [NUM_CLIENTS-1:0]         cl_wr_rsp_valid;
    logic [DATA_W-1:0]              cl_rsp_data;
    logic [MDATA_W-1:0]             cl_rsp_mdata;
    logic [NUM_CLIENTS-1:0]         cl_busy;
    logic                           bad_id_err;

    modport slave (
        input  cl_rd_valid, cl_rd_addr, cl_rd_mdata,
        input  cl_wr_valid, cl_wr_addr, cl_wr_data, cl_wr_mdata,
        input  fiu_c0_almfull, fiu_c1_almfull,
        input  fiu_rd_rsp_valid, fiu_rd_rsp_mdata, fiu_rd_rsp_data,
        input  fiu_wr_rsp_valid, fiu_wr_rsp_mdata,
        output cl_rd_ready, cl_wr_ready,
        output fiu_c0_valid, fiu_c0_addr, fiu_c0_mdata, fiu_c0_flags,
        output fiu_c1_valid, fiu_c1_addr, fiu_c1_data, fiu_c1_mdata, fiu_c1_flags,
        output cl_rd_rsp_valid, cl_wr_rsp_valid, cl_rsp_data, cl_rsp_mdata,
        output cl_busy, bad_id_err
    );

    modport master (
        output cl_rd_valid, cl_rd_addr, cl_rd_mdata,
        output cl_wr_valid, cl_wr_addr, cl_wr_data, cl_wr_mdata,
        output fiu_c0_almfull, fiu_c1_almfull,
        output fiu_rd_rsp_valid, fiu_rd_rsp_mdata, fiu_rd_rsp_data,
        output fiu_wr_rsp_valid, fiu_wr_rsp_mdata,
        input  cl_rd_ready, cl_wr_ready,
        input  fiu_c0_valid, fiu_c0_addr, fiu_c0_mdata, fiu_c0_flags,
        input  fiu_c1_valid, fiu_c1_addr, fiu_c1_data, fiu_c1_mdata, fiu_c1_flags,
        input  cl_rd_rsp_valid, cl_wr_rsp_valid, cl_rsp_data, cl_rsp_mdata,
        input  cl_busy, bad_id_err
    );
endinterface

// File: rtl/cci_channel_mux.sv
// Shares one CCI-P port between NUM_CLIENTS engines: independent round-robin read and
// write arbitration with per-client outstanding limits, and ID-based response routing.
module cci_channel_mux #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 42,
    parameter int DATA_W      = 512,
    parameter int MDATA_W     = 16,
    parameter int MAX_OUTST   = 64
) (
    input  logic             clk,
    input  logic             reset,
    cci_channel_mux_if.slave bus
);
    localparam int                ID_W    = $clog2(NUM_CLIENTS);
    localparam int                TAG_W   = MDATA_W - ID_W;
    localparam int                CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [ID_W:0]     NUM_ID  = (ID_W + 1)'(NUM_CLIENTS);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_CLIENTS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Returns {found, index}: first eligible client at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] elig,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int unsigned   idx;
        res = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= 32'(NUM_CLIENTS)) begin
                idx = idx - 32'(NUM_CLIENTS);
            end else begin
                idx = idx;
            end
            if (elig[idx[ID_W-1:0]]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [ID_W-1:0]        rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]       rd_cnt_r [NUM_CLIENTS];
    logic [CNT_W-1:0]       wr_cnt_r [NUM_CLIENTS];
    logic [CNT_W-1:0]       rd_cnt_nxt_s [NUM_CLIENTS];
    logic [CNT_W-1:0]       wr_cnt_nxt_s [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] rd_elig_s, wr_elig_s, rd_gnt_s, wr_gnt_s;
    logic [ID_W:0]          rd_pick_s, wr_pick_s;
    logic [ADDR_W-1:0]      rd_addr_s, wr_addr_s;
    logic [DATA_W-1:0]      wr_data_s;
    logic [TAG_W-1:0]       rd_tag_s, wr_tag_s;
    logic [ID_W-1:0]        rd_rsp_id_s, wr_rsp_id_s;
    logic                   rd_rsp_ok_s, wr_rsp_ok_s, rd_rsp_bad_s, wr_rsp_bad_s;
    logic [NUM_CLIENTS-1:0] rd_rsp_hit_s, wr_rsp_hit_s, busy_nxt_s;

    logic                   c0_valid_r, c1_valid_r;
    logic [ADDR_W-1:0]      c0_addr_r, c1_addr_r;
    logic [DATA_W-1:0]      c1_data_r;
    logic [MDATA_W-1:0]     c0_mdata_r, c1_mdata_r;
    logic [2:0]             c0_flags_r, c1_flags_r;
    logic [NUM_CLIENTS-1:0] rd_rsp_valid_r, wr_rsp_valid_r, busy_r;
    logic [DATA_W-1:0]      rsp_data_r;
    logic [MDATA_W-1:0]     rsp_mdata_r;
    logic                   bad_id_r;
    logic                   unused_s;

    // Eligibility and one-hot grant; readies are forced low while reset is held.
    always_comb begin
        rd_elig_s = '0;
        wr_elig_s = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_elig_s[i] = bus.cl_rd_valid[i] && (rd_cnt_r[i] < CNT_MAX) && !bus.fiu_c0_almfull && !reset;
            wr_elig_s[i] = bus.cl_wr_valid[i] && (wr_cnt_r[i] < CNT_MAX) && !bus.fiu_c1_almfull && !reset;
        end
        rd_pick_s = rr_pick(rd_elig_s, rd_ptr_r);
        wr_pick_s = rr_pick(wr_elig_s, wr_ptr_r);
        rd_gnt_s  = '0;
        wr_gnt_s  = '0;
        if (rd_pick_s[ID_W]) begin
            rd_gnt_s[rd_pick_s[ID_W-1:0]] = 1'b1;
        end else begin
            rd_gnt_s = '0;
        end
        if (wr_pick_s[ID_W]) begin
            wr_gnt_s[wr_pick_s[ID_W-1:0]] = 1'b1;
        end else begin
            wr_gnt_s = '0;
        end
    end

    // Payload select from the granted client (AND-OR mux on the one-hot grant).
    always_comb begin
        rd_addr_s = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        rd_tag_s  = '0;
        wr_tag_s  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_addr_s = rd_addr_s | (rd_gnt_s[i] ? bus.cl_rd_addr[i*ADDR_W +: ADDR_W] : '0);
            rd_tag_s  = rd_tag_s  | (rd_gnt_s[i] ? bus.cl_rd_mdata[i*MDATA_W +: TAG_W] : '0);
            wr_addr_s = wr_addr_s | (wr_gnt_s[i] ? bus.cl_wr_addr[i*ADDR_W +: ADDR_W] : '0);
            wr_data_s = wr_data_s | (wr_gnt_s[i] ? bus.cl_wr_data[i*DATA_W +: DATA_W] : '0);
            wr_tag_s  = wr_tag_s  | (wr_gnt_s[i] ? bus.cl_wr_mdata[i*MDATA_W +: TAG_W] : '0);
        end
    end

    // Response ID decode and counter next-state; a response at zero count cannot underflow.
    always_comb begin
        rd_rsp_id_s  = bus.fiu_rd_rsp_mdata[MDATA_W-1 -: ID_W];
        wr_rsp_id_s  = bus.fiu_wr_rsp_mdata[MDATA_W-1 -: ID_W];
        rd_rsp_ok_s  = bus.fiu_rd_rsp_valid && ({1'b0, rd_rsp_id_s} < NUM_ID);
        wr_rsp_ok_s  = bus.fiu_wr_rsp_valid && ({1'b0, wr_rsp_id_s} < NUM_ID);
        rd_rsp_bad_s = bus.fiu_rd_rsp_valid && !rd_rsp_ok_s;
        wr_rsp_bad_s = bus.fiu_wr_rsp_valid && !wr_rsp_ok_s;
        rd_rsp_hit_s = '0;
        wr_rsp_hit_s = '0;
        busy_nxt_s   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_rsp_hit_s[i] = rd_rsp_ok_s && (rd_rsp_id_s == ID_W'(i));
            wr_rsp_hit_s[i] = wr_rsp_ok_s && (wr_rsp_id_s == ID_W'(i));
            case ({rd_gnt_s[i], rd_rsp_hit_s[i] && (rd_cnt_r[i] != '0)})
                2'b10:   rd_cnt_nxt_s[i] = rd_cnt_r[i] + CNT_ONE;
                2'b01:   rd_cnt_nxt_s[i] = rd_cnt_r[i] - CNT_ONE;
                default: rd_cnt_nxt_s[i] = rd_cnt_r[i];
            endcase
            case ({wr_gnt_s[i], wr_rsp_hit_s[i] && (wr_cnt_r[i] != '0)})
                2'b10:   wr_cnt_nxt_s[i] = wr_cnt_r[i] + CNT_ONE;
                2'b01:   wr_cnt_nxt_s[i] = wr_cnt_r[i] - CNT_ONE;
                default: wr_cnt_nxt_s[i] = wr_cnt_r[i];
            endcase
            busy_nxt_s[i] = (rd_cnt_nxt_s[i] != '0) || (wr_cnt_nxt_s[i] != '0);
        end
    end

    // Round-robin pointers, outstanding counters and busy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            busy_r   <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                rd_cnt_r[i] <= '0;
                wr_cnt_r[i] <= '0;
            end
        end else begin
            if (rd_pick_s[ID_W]) begin
                rd_ptr_r <= (rd_pick_s[ID_W-1:0] == LAST_ID) ? '0 : rd_pick_s[ID_W-1:0] + ID_W'(1);
            end
            if (wr_pick_s[ID_W]) begin
                wr_ptr_r <= (wr_pick_s[ID_W-1:0] == LAST_ID) ? '0 : wr_pick_s[ID_W-1:0] + ID_W'(1);
            end
            busy_r <= busy_nxt_s;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                rd_cnt_r[i] <= rd_cnt_nxt_s[i];
                wr_cnt_r[i] <= wr_cnt_nxt_s[i];
            end
        end
    end

    // Host request registers; the client ID replaces the top mdata bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_valid_r <= 1'b0;
            c0_addr_r  <= '0;
            c0_mdata_r <= '0;
            c0_flags_r <= 3'b000;
            c1_valid_r <= 1'b0;
            c1_addr_r  <= '0;
            c1_data_r  <= '0;
            c1_mdata_r <= '0;
            c1_flags_r <= 3'b000;
        end else begin
            c0_valid_r <= rd_pick_s[ID_W];
            c0_flags_r <= rd_pick_s[ID_W] ? 3'b111 : 3'b000;
            c1_valid_r <= wr_pick_s[ID_W];
            c1_flags_r <= wr_pick_s[ID_W] ? 3'b111 : 3'b000;
            if (rd_pick_s[ID_W]) begin
                c0_addr_r  <= rd_addr_s;
                c0_mdata_r <= {rd_pick_s[ID_W-1:0], rd_tag_s};
            end
            if (wr_pick_s[ID_W]) begin
                c1_addr_r  <= wr_addr_s;
                c1_data_r  <= wr_data_s;
                c1_mdata_r <= {wr_pick_s[ID_W-1:0], wr_tag_s};
            end
        end
    end

    // Response routing; the read tag wins the shared mdata bus when both arrive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_rsp_valid_r <= '0;
            wr_rsp_valid_r <= '0;
            rsp_data_r     <= '0;
            rsp_mdata_r    <= '0;
            bad_id_r       <= 1'b0;
        end else begin
            rd_rsp_valid_r <= rd_rsp_hit_s;
            wr_rsp_valid_r <= wr_rsp_hit_s;
            bad_id_r       <= bad_id_r | rd_rsp_bad_s | wr_rsp_bad_s;
            if (rd_rsp_ok_s) begin
                rsp_data_r  <= bus.fiu_rd_rsp_data;
                rsp_mdata_r <= {{ID_W{1'b0}}, bus.fiu_rd_rsp_mdata[TAG_W-1:0]};
            end else if (wr_rsp_ok_s) begin
                rsp_mdata_r <= {{ID_W{1'b0}}, bus.fiu_wr_rsp_mdata[TAG_W-1:0]};
            end
        end
    end

    assign bus.cl_rd_ready     = rd_gnt_s;
    assign bus.cl_wr_ready     = wr_gnt_s;
    assign bus.fiu_c0_valid    = c0_valid_r;
    assign bus.fiu_c0_addr     = c0_addr_r;
    assign bus.fiu_c0_mdata    = c0_mdata_r;
    assign bus.fiu_c0_flags    = c0_flags_r;
    assign bus.fiu_c1_valid    = c1_valid_r;
    assign bus.fiu_c1_addr     = c1_addr_r;
    assign bus.fiu_c1_data     = c1_data_r;
    assign bus.fiu_c1_mdata    = c1_mdata_r;
    assign bus.fiu_c1_flags    = c1_flags_r;
    assign bus.cl_rd_rsp_valid = rd_rsp_valid_r;
    assign bus.cl_wr_rsp_valid = wr_rsp_valid_r;
    assign bus.cl_rsp_data     = rsp_data_r;
    assign bus.cl_rsp_mdata    = rsp_mdata_r;
    assign bus.cl_busy         = busy_r;
    assign bus.bad_id_err      = bad_id_r;

    // Client-supplied ID bits are overwritten, so only the tag bits are consumed.
    assign unused_s = ^{bus.cl_rd_mdata, bus.cl_wr_mdata};
endmodule

// File: doc/cci_channel_mux.md
CCI_CHANNEL_MUX -- requirements
Module: cci_channel_mux

Interface
REQ-001 Param NUM_CLIENTS, 4, number of engine channels sharing one CCI-P port (2..16).
REQ-002 Param ADDR_W, 42, cache-line address width.
REQ-003 Param DATA_W, 512, line data width.
REQ-004 Param MDATA_W, 16, metadata width; top ID_W=clog2(NUM_CLIENTS) bits carry client ID.
REQ-005 Param MAX_OUTST, 64, per-client outstanding-request limit per channel.
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cl_rd_valid / cl_rd_ready  in / out  N  per-client read request handshake.
REQ-009 cl_rd_addr, cl_rd_mdata  in  N*ADDR_W, N*MDATA_W  read address, client tag (low MDATA_W-ID_W bits used).
REQ-010 cl_wr_valid / cl_wr_ready  in / out  N  per-client write request handshake.
REQ-011 cl_wr_addr, cl_wr_data, cl_wr_mdata  in  N*ADDR_W, N*DATA_W, N*MDATA_W  write payload.
REQ-012 fiu_c0_valid, fiu_c0_addr, fiu_c0_mdata, fiu_c0_flags  out  1, ADDR_W, MDATA_W, 3  read request to host; flags = {addrIsVirtual, mapVAtoPhysChannel, checkLoadStoreOrder}.
REQ-013 fiu_c1_valid, fiu_c1_addr, fiu_c1_data, fiu_c1_mdata, fiu_c1_flags  out  1, ADDR_W, DATA_W, MDATA_W, 3  write request to host, same flag layout.
REQ-014 fiu_c0_almfull, fiu_c1_almfull  in  1  host back-pressure.
REQ-015 fiu_rd_rsp_valid, fiu_rd_rsp_mdata, fiu_rd_rsp_data  in  1, MDATA_W, DATA_W  read response.
REQ-016 fiu_wr_rsp_valid, fiu_wr_rsp_mdata  in  1, MDATA_W  write acknowledge.
REQ-017 cl_rd_rsp_valid, cl_wr_rsp_valid  out  N  one-hot routed responses.
REQ-018 cl_rsp_data, cl_rsp_mdata  out  DATA_W, MDATA_W  shared response payload, ID bits zeroed.
REQ-019 cl_busy  out  N  client has reads or writes outstanding.
REQ-020 bad_id_err  out  1  sticky: response carried ID >= NUM_CLIENTS.

Function
REQ-021 Read and write channels SHALL arbitrate independently, each with its own round-robin pointer.
REQ-022 Client eligible on a channel iff valid high and its outstanding count on that channel < MAX_OUTST.
REQ-023 Grant only when the channel's almfull is low; at most one grant per channel per cycle; cl_*_ready is the one-hot grant, combinational.
REQ-024 Round-robin: search starts at pointer, pointer moves to granted index+1 mod N; no grant leaves pointer unchanged.
REQ-025 Accepted request SHALL appear on fiu_c*_ outputs exactly 1 cycle later (registered), valid for one cycle.
REQ-026 Outgoing mdata = {client ID, low MDATA_W-ID_W bits of client mdata}.
REQ-027 fiu_c*_flags = 3'b111 when fiu_c*_valid, else 3'b000; fiu_*_valid low in idle cycles.
REQ-028 Responses SHALL be registered: cl_*_rsp_valid[ID] pulses 1 cycle after fiu response, payload held with it.
REQ-029 Read and write responses in the same cycle SHALL both be delivered; cl_rsp_data carries read data, cl_rsp_mdata carries read tag priority.
REQ-030 Outstanding counters (width clog2(MAX_OUTST+1)): +1 on grant, -1 on response; simultaneous grant and response on same client/channel leaves count unchanged.
REQ-031 Response with ID >= NUM_CLIENTS: dropped, no counter change, bad_id_err set until reset.
REQ-032 Counter decrement at zero (spurious response) SHALL hold at zero.
REQ-033 cl_busy[i] = read count or write count of client i nonzero, registered.

Reset
REQ-034 On reset assertion, immediately: all valids, readies, cl_busy, bad_id_err = 0; counters and pointers = 0; data/addr registers = 0.
REQ-035 Requests in flight at reset are forgotten; responses arriving after reset release for a zero counter obey REQ-032.

Verification
REQ-036 N=4, all four rd_valid high, almfull low -> grants 0,1,2,3,0 on consecutive cycles; fiu_c0_mdata[15:14] = 0,1,2,3,0.
REQ-037 Client 2 rd_valid with fiu_c0_almfull high 5 cycles -> no ready for 5 cycles, grant cycle after almfull drops, fiu_c0_flags=3'b111.
REQ-038 MAX_OUTST=2, client 1 issues 3 writes without acks -> third stalls; ack mdata ID=1 -> third accepted next cycle.
REQ-039 Read response mdata=16'h8005 -> cl_rd_rsp_valid=4'b0100 next cycle, cl_rsp_mdata=16'h0005, cl_busy[2] drops when count hits 0.
REQ-040 Same-cycle grant and response for client 0 at count 1 -> count stays 1, cl_busy[0] stays high.
REQ-041 Reset asserted mid-burst -> all outputs 0 within same cycle, grants resume from client 0 after release.
